kb_field_editor: RTL and testbench
==================================

// Module: kb_field_editor
// PURPOSE
//  Parametrised keyboard-to-register command translator: turns PS/2 scancode pairs into
//  (address, BCD data, commit) writes for the controller's clock/date/timer register file.
//  Sits between the PS/2 receiver (KBBuffer) and the controller port-id decoder.
//  Adds explicit EDIT/COMMIT state machine, commit handshake, digit counting and
//  generic group/field/digit counts.
// PARAMETERS
//  NUM_GROUPS       3      editable groups, 1..4; selected by F1,F2,F3,F4 (05,06,04,0C)
//  FIELDS_PER_GROUP 3      fields per group, 1..8; group g field i -> address g*FIELDS_PER_GROUP+i
//  DIGITS           2      BCD digits per field, 1..4; Data width = 4*DIGITS
//  ADDR_W           8      Address width; must hold NUM_GROUPS*FIELDS_PER_GROUP and ACT_ADDR
//  ACT_ADDR         10     address written by F11/F12 (timer activate/deactivate)
//  ACT_VAL          8      data written by F11
//  ACK_SEL          2'b10  DataSelect value that acknowledges a commit
// PORTS
//  CLK          in   1         system clock, all state on rising edge
//  RESET        in   1         asynchronous, active-low reset
//  KBBuffer     in   16        [15:8] previous byte, [7:0] latest scancode byte
//  Read_Strobe  in   1         controller read strobe
//  DataSelect   in   2         controller port select during Read_Strobe
//  Address      out  ADDR_W    target register address
//  Data         out  4*DIGITS  BCD value, MS digit in top nibble
//  Commit       out  1         write request, held until acknowledged
//  Busy         out  1         1 when state != IDLE
// BEHAVIOUR
//  - Reset (RESET=0, async): state IDLE, Address=0, Data=0, Commit=0, Busy=0, KBBuffer shadow=0,
//    field idx=0, digit count=0.
//  - Key event: one-cycle pulse when KBBuffer != registered shadow; shadow updated that cycle.
//    Event acted on in the same edge (outputs change 1 cycle after KBBuffer changes).
//  - Make code: KBBuffer[15:8] != F0. Break codes (F0 xx) and E0-prefixed codes ignored.
//  - States IDLE, EDIT, COMMIT. Commit=1 exactly in COMMIT.
//  - IDLE: F<g> (g<NUM_GROUPS) -> EDIT, idx=0, Address=g*FPG, Data=0, count=0.
//    F11 -> Address=ACT_ADDR, Data=ACT_VAL, COMMIT. F12 -> Address=ACT_ADDR, Data=0, COMMIT.
//    Digits, Tab, Enter ignored. F<g> with g>=NUM_GROUPS ignored.
//  - EDIT: digit 0-9 (45,16,1E,26,25,2E,36,3D,3E,46): Data={Data[4*DIGITS-5:0],digit};
//    oldest digit dropped; count saturates at DIGITS.
//    Tab: idx=(idx==FPG-1)?0:idx+1, Address=group base+idx, Data=0, count=0 (wraps to field 0).
//    F<g>: reselect group as in IDLE. F11/F12: as in IDLE (abandons edit).
//    Enter: count>0 -> COMMIT; count==0 -> ignored, stay EDIT.
//  - COMMIT: all keys except Esc ignored; Address/Data frozen.
//    Read_Strobe=1 && DataSelect==ACK_SEL -> IDLE, Address=0, Data=0, idx=0, count=0;
//    Commit low the following cycle. Strobe with other DataSelect: no effect.
//  - Esc make (76) in any state -> IDLE with all registers cleared as at reset
//    (shadow keeps current KBBuffer).
//  - Simultaneous ack and key event in COMMIT: ack wins, key event dropped (shadow still updated).
//  - Repeated identical scancode pair produces no event (typematic repeat ignored).
//  - Reset asserted mid-COMMIT: Commit drops asynchronously; no write implied.
// TESTING
//  - Reset: drive RESET=0 mid-activity -> Address=0, Data=0, Commit=0, Busy=0 immediately.
//  - F2(06), digits 1(16),2(1E),3(26), Enter(5A) -> Address=3, Data=8'h23, Commit=1;
//    Read_Strobe with DataSelect=2'b10 -> Commit=0 next cycle, Address=0.
//  - F1(05), Tab x3 (FPG=3) -> Address 1,2,0 (wrap); Enter with no digits -> stays EDIT,
//    Commit=0.
//  - F11(78) from IDLE -> Address=10, Data=8, Commit=1; Read_Strobe with DataSelect=2'b01
//    -> Commit stays 1.
//  - F3(04), 5(2E), Esc(76) -> Address=0, Data=0, Busy=0; then F0 2E break -> no change.
//  - DIGITS=3, NUM_GROUPS=4: F4(0C), digits 9,8,7,6 -> Address=9, Data=12'h876;
//    key event and ack in same cycle in COMMIT -> IDLE, key dropped.

Source files
------------

// File: rtl/kb_field_editor_if.sv
// Keyboard-to-register command bus: scancode input, controller ack strobe, write request out.
// Latency: none (signal bundle only).
// Backpressure: Commit is held by the slave until the master acks it via Read_Strobe/DataSelect.
//
// Signals:
//   KBBuffer    master->slave  [15:8] previous byte, [7:0] latest scancode byte
//   Read_Strobe master->slave  controller read strobe
//   DataSelect  master->slave  controller port select while Read_Strobe is high
//   Address     slave->master  target register address
//   Data        slave->master  BCD value, most significant digit in the top nibble
//   Commit      slave->master  write request, held until acknowledged
//   Busy        slave->master  editor is not idle
interface kb_field_editor_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [15:0]       KBBuffer;
    logic              Read_Strobe;
    logic [1:0]        DataSelect;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Data;
    logic              Commit;
    logic              Busy;

    modport master (
        output KBBuffer, Read_Strobe, DataSelect,
        input  Address, Data, Commit, Busy
    );

    modport slave (
        input  KBBuffer, Read_Strobe, DataSelect,
        output Address, Data, Commit, Busy
    );
endinterface

// File: rtl/kb_field_editor.sv
// Translates PS/2 scancode pairs into (Address, BCD Data, Commit) register-file writes.
// Latency: outputs update one cycle after KBBuffer changes or after the ack strobe.
// Backpressure: Commit held (Address/Data frozen, keys other than Esc ignored) until acked.
//
// Ports:
//   CLK    rising-edge clock for all state
//   RESET  asynchronous active-low reset
//   bus    kb_field_editor_if.slave (KBBuffer, Read_Strobe, DataSelect in;
//          Address, Data, Commit, Busy out)
module kb_field_editor #(
    parameter int         NUM_GROUPS       = 3,
    parameter int         FIELDS_PER_GROUP = 3,
    parameter int         DIGITS           = 2,
    parameter int         ADDR_W           = 8,
    parameter int         ACT_ADDR         = 10,
    parameter int         ACT_VAL          = 8,
    parameter logic [1:0] ACK_SEL          = 2'b10
) (
    input  logic             CLK,
    input  logic             RESET,
    kb_field_editor_if.slave bus
);
    localparam int DATA_W = 4 * DIGITS;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_TAB   = 8'h0D;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_F11   = 8'h78;
    localparam logic [7:0] SC_F12   = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [15:0]       shadow_q;
    logic [1:0]        grp_q, grp_nxt;
    logic [2:0]        idx_q, idx_nxt;
    logic [2:0]        cnt_q, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;

    logic       key_evt;
    logic       make_evt;
    logic       ack;
    logic [7:0] code;
    logic       grp_hit;
    logic [1:0] grp_sel;
    logic       dig_hit;
    logic [3:0] dig_val;
    logic       do_clear;

    function automatic logic [ADDR_W-1:0] field_addr(input logic [1:0] g, input logic [2:0] i);
        return ADDR_W'(int'(g) * FIELDS_PER_GROUP + int'(i));
    endfunction

    assign code = bus.KBBuffer[7:0];
    // A changed scancode pair is one key event; a repeated identical pair is typematic noise.
    assign key_evt  = (bus.KBBuffer != shadow_q);
    assign make_evt = key_evt && (bus.KBBuffer[15:8] != SC_BREAK) && (bus.KBBuffer[15:8] != SC_EXT);
    assign ack      = bus.Read_Strobe && (bus.DataSelect == ACK_SEL);

    // Scancode decode: F1..F4 group select and 0-9 digit keys.
    always_comb begin
        grp_hit = 1'b1;
        grp_sel = 2'd0;
        case (code)
            8'h05:   grp_sel = 2'd0;
            8'h06:   grp_sel = 2'd1;
            8'h04:   grp_sel = 2'd2;
            8'h0C:   grp_sel = 2'd3;
            default: grp_hit = 1'b0;
        endcase
        if (int'(grp_sel) >= NUM_GROUPS) grp_hit = 1'b0;

        dig_hit = 1'b1;
        dig_val = 4'd0;
        case (code)
            8'h45:   dig_val = 4'd0;
            8'h16:   dig_val = 4'd1;
            8'h1E:   dig_val = 4'd2;
            8'h26:   dig_val = 4'd3;
            8'h25:   dig_val = 4'd4;
            8'h2E:   dig_val = 4'd5;
            8'h36:   dig_val = 4'd6;
            8'h3D:   dig_val = 4'd7;
            8'h3E:   dig_val = 4'd8;
            8'h46:   dig_val = 4'd9;
            default: dig_hit = 1'b0;
        endcase
    end

    // State register (shadow always tracks KBBuffer, even when the event is dropped).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            grp_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            shadow_q <= bus.KBBuffer;
            grp_q    <= grp_nxt;
            idx_q    <= idx_nxt;
            cnt_q    <= cnt_nxt;
            addr_q   <= addr_nxt;
            data_q   <= data_nxt;
        end
    end

    // Next-state logic. The ack is checked first so it wins over a same-cycle key event.
    always_comb begin
        state_nxt = state_q;
        grp_nxt   = grp_q;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;

        do_clear = ((state_q == COMMIT) && ack) || (make_evt && (code == SC_ESC));

        if (do_clear) begin
            state_nxt = IDLE;
            grp_nxt   = '0;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            addr_nxt  = '0;
            data_nxt  = '0;
        end else if (make_evt && (state_q != COMMIT)) begin
            if (grp_hit) begin
                state_nxt = EDIT;
                grp_nxt   = grp_sel;
                idx_nxt   = '0;
                cnt_nxt   = '0;
                addr_nxt  = field_addr(grp_sel, 3'd0);
                data_nxt  = '0;
            end else if ((code == SC_F11) || (code == SC_F12)) begin
                state_nxt = COMMIT;
                addr_nxt  = ADDR_W'(ACT_ADDR);
                data_nxt  = (code == SC_F11) ? DATA_W'(ACT_VAL) : '0;
            end else if (state_q == EDIT) begin
                if (dig_hit) begin
                    // Shift in from the right; the oldest digit falls off the top.
                    data_nxt = (data_q << 4) | DATA_W'(dig_val);
                    if (int'(cnt_q) < DIGITS) cnt_nxt = cnt_q + 3'd1;
                end else if (code == SC_TAB) begin
                    idx_nxt  = (int'(idx_q) == FIELDS_PER_GROUP - 1) ? 3'd0 : idx_q + 3'd1;
                    addr_nxt = field_addr(grp_q, idx_nxt);
                    data_nxt = '0;
                    cnt_nxt  = '0;
                end else if ((code == SC_ENTER) && (cnt_q != 3'd0)) begin
                    state_nxt = COMMIT;
                end
            end
        end
    end

    // Outputs: Commit/Busy decode straight from the state so reset drops them at once.
    always_comb begin
        bus.Address = addr_q;
        bus.Data    = data_q;
        bus.Commit  = (state_q == COMMIT);
        bus.Busy    = (state_q != IDLE);
    end
endmodule

// File: tb/tb_kb_field_editor.sv
`timescale 1ns/1ps
module tb_kb_field_editor;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    kb_field_editor_if #(.ADDR_W(8), .DATA_W(8))  b0();
    kb_field_editor_if #(.ADDR_W(8), .DATA_W(12)) b1();

    kb_field_editor #(.NUM_GROUPS(3), .FIELDS_PER_GROUP(3), .DIGITS(2), .ADDR_W(8),
                      .ACT_ADDR(10), .ACT_VAL(8), .ACK_SEL(2'b10))
        u0 (.CLK(CLK), .RESET(RESET), .bus(b0));
    kb_field_editor #(.NUM_GROUPS(4), .FIELDS_PER_GROUP(3), .DIGITS(3), .ADDR_W(8),
                      .ACT_ADDR(10), .ACT_VAL(8), .ACK_SEL(2'b10))
        u1 (.CLK(CLK), .RESET(RESET), .bus(b1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] kb, input logic rs, input logic [1:0] ds);
        b0.KBBuffer = kb; b0.Read_Strobe = rs; b0.DataSelect = ds;
        b1.KBBuffer = kb; b1.Read_Strobe = rs; b1.DataSelect = ds;
    endtask

    task automatic step(input logic [15:0] kb, input logic rs, input logic [1:0] ds);
        drive(kb, rs, ds);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string n, input int a, input int d, input int c, input int b);
        chk({n, " addr"},   32'(b1.Address), 32'(a));
        chk({n, " data"},   32'(b1.Data),    32'(d));
        chk({n, " commit"}, 32'(b1.Commit),  32'(c));
        chk({n, " busy"},   32'(b1.Busy),    32'(b));
    endtask

    // ---------------- directed table (instance u0: 3 groups, 2 digits) ----------------
    typedef struct packed {
        logic [15:0] kb;
        logic        rs;
        logic [1:0]  ds;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        commit;
        logic        busy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [15:0] kb, input logic rs, input logic [1:0] ds,
                                input logic [7:0] a, input logic [7:0] d, input logic c, input logic b);
        vec_t v;
        v.kb = kb; v.rs = rs; v.ds = ds; v.addr = a; v.data = d; v.commit = c; v.busy = b;
        tbl.push_back(v);
    endfunction

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 editing, 2 write pending; act: 0 field write, 1 activate, 2 deactivate
    typedef struct {
        int mode; int grp; int fld; int nd; int val; int act;
    } mdl_t;

    function automatic mdl_t mclear();
        mdl_t r;
        r.mode = 0; r.grp = 0; r.fld = 0; r.nd = 0; r.val = 0; r.act = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int ng, input int dg,
                                   input bit evt, input logic [15:0] kb, input bit ack);
        mdl_t r = m;
        int c = int'(kb[7:0]);
        int p = int'(kb[15:8]);
        int g = -1;
        int d = -1;
        int dc[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
        if (m.mode == 2 && ack) return mclear();
        if (!evt || p == 'hF0 || p == 'hE0) return r;
        if (c == 'h76) return mclear();
        if (m.mode == 2) return r;
        case (c)
            'h05: g = 0;
            'h06: g = 1;
            'h04: g = 2;
            'h0C: g = 3;
            default: g = -1;
        endcase
        for (int k = 0; k < 10; k++) if (dc[k] == c) d = k;
        if (g >= 0) begin
            if (g < ng) begin
                r = mclear(); r.mode = 1; r.grp = g;
            end
            return r;
        end
        if (c == 'h78) begin r.mode = 2; r.act = 1; return r; end
        if (c == 'h07) begin r.mode = 2; r.act = 2; return r; end
        if (m.mode != 1) return r;
        if (d >= 0) begin
            r.val = (r.val * 16 + d) % (1 << (4 * dg));
            if (r.nd < dg) r.nd++;
        end else if (c == 'h0D) begin
            r.fld = (r.fld + 1) % 3; r.val = 0; r.nd = 0;
        end else if (c == 'h5A && r.nd > 0) begin
            r.mode = 2;
        end
        return r;
    endfunction

    function automatic int exp_addr(input mdl_t m);
        if (m.mode == 0) return 0;
        if (m.act != 0) return 10;
        return m.grp * 3 + m.fld;
    endfunction

    function automatic int exp_data(input mdl_t m);
        if (m.mode == 0) return 0;
        if (m.act == 1) return 8;
        if (m.act == 2) return 0;
        return m.val;
    endfunction

    logic [7:0]  rnd_codes [21] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h78, 8'h07, 8'h0D, 8'h5A, 8'h76,
                                    8'hF0, 8'hE0, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                    8'h3D, 8'h3E, 8'h46};

    initial begin
        mdl_t        m0, m1;
        logic [15:0] kbw, prev_kb;
        logic [7:0]  nb;
        logic        rs;
        logic [1:0]  ds;
        bit          evt;

        // Reset state while reset is held.
        RESET = 1'b0;
        drive(16'h0000, 1'b0, 2'b00);
        #12;
        chk("reset u0 addr",   32'(b0.Address), 32'd0);
        chk("reset u0 data",   32'(b0.Data),    32'd0);
        chk("reset u0 commit", 32'(b0.Commit),  32'd0);
        chk("reset u0 busy",   32'(b0.Busy),    32'd0);
        chk1("reset u1", 0, 0, 0, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        //   kb        rs    ds     addr   data   c     b
        add(16'h0006, 1'b0, 2'd0, 8'h03, 8'h00, 1'b0, 1'b1); // F2
        add(16'h06F0, 1'b0, 2'd0, 8'h03, 8'h00, 1'b0, 1'b1);
        add(16'hF006, 1'b0, 2'd0, 8'h03, 8'h00, 1'b0, 1'b1); // break
        add(16'h0616, 1'b0, 2'd0, 8'h03, 8'h01, 1'b0, 1'b1); // 1
        add(16'h161E, 1'b0, 2'd0, 8'h03, 8'h12, 1'b0, 1'b1); // 2
        add(16'h1E26, 1'b0, 2'd0, 8'h03, 8'h23, 1'b0, 1'b1); // 3, oldest dropped
        add(16'h265A, 1'b0, 2'd0, 8'h03, 8'h23, 1'b1, 1'b1); // Enter
        add(16'h265A, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0); // ack
        add(16'h5A05, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1); // F1
        add(16'h050D, 1'b0, 2'd0, 8'h01, 8'h00, 1'b0, 1'b1); // Tab
        add(16'h0DF0, 1'b0, 2'd0, 8'h01, 8'h00, 1'b0, 1'b1);
        add(16'hF00D, 1'b0, 2'd0, 8'h01, 8'h00, 1'b0, 1'b1); // break
        add(16'h0D0D, 1'b0, 2'd0, 8'h02, 8'h00, 1'b0, 1'b1); // Tab
        add(16'h0D0D, 1'b0, 2'd0, 8'h02, 8'h00, 1'b0, 1'b1); // repeat, no event
        add(16'hE00D, 1'b0, 2'd0, 8'h02, 8'h00, 1'b0, 1'b1); // E0-prefixed
        add(16'h0D0D, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1); // Tab wraps
        add(16'h0D5A, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1); // Enter, no digits
        add(16'h5A78, 1'b0, 2'd0, 8'h0A, 8'h08, 1'b1, 1'b1); // F11 from EDIT
        add(16'h5A78, 1'b1, 2'd1, 8'h0A, 8'h08, 1'b1, 1'b1); // wrong select
        add(16'h7816, 1'b0, 2'd0, 8'h0A, 8'h08, 1'b1, 1'b1); // digit in COMMIT
        add(16'h7816, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0); // ack
        add(16'h1604, 1'b0, 2'd0, 8'h06, 8'h00, 1'b0, 1'b1); // F3
        add(16'h042E, 1'b0, 2'd0, 8'h06, 8'h05, 1'b0, 1'b1); // 5
        add(16'h2E76, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); // Esc
        add(16'h76F0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        add(16'hF02E, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); // break of 5
        add(16'h2E0C, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); // F4 beyond NUM_GROUPS
        add(16'h0C16, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); // digit in IDLE
        add(16'h1607, 1'b0, 2'd0, 8'h0A, 8'h00, 1'b1, 1'b1); // F12
        add(16'h0776, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); // Esc in COMMIT

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].kb, tbl[i].rs, tbl[i].ds);
            chk($sformatf("vec%0d addr", i),   32'(b0.Address), 32'(tbl[i].addr));
            chk($sformatf("vec%0d data", i),   32'(b0.Data),    32'(tbl[i].data));
            chk($sformatf("vec%0d commit", i), 32'(b0.Commit),  32'(tbl[i].commit));
            chk($sformatf("vec%0d busy", i),   32'(b0.Busy),    32'(tbl[i].busy));
        end

        // u1: 4 groups, 3 digits.
        step(16'h0076, 1'b0, 2'd0);
        chk1("u1 esc", 0, 0, 0, 0);
        step(16'h760C, 1'b0, 2'd0);
        chk1("u1 F4", 9, 0, 0, 1);
        step(16'h0C46, 1'b0, 2'd0);
        chk1("u1 d9", 9, 'h009, 0, 1);
        step(16'h463E, 1'b0, 2'd0);
        chk1("u1 d8", 9, 'h098, 0, 1);
        step(16'h3E3D, 1'b0, 2'd0);
        chk1("u1 d7", 9, 'h987, 0, 1);
        step(16'h3D36, 1'b0, 2'd0);
        chk1("u1 d6", 9, 'h876, 0, 1);
        step(16'h365A, 1'b0, 2'd0);
        chk1("u1 enter", 9, 'h876, 1, 1);
        step(16'h5A05, 1'b1, 2'd2); // F1 arrives with the ack: ack wins
        chk1("u1 ack+key", 0, 0, 0, 0);
        step(16'h5A05, 1'b0, 2'd0);
        chk1("u1 key dropped", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a pending write.
        step(16'h0578, 1'b0, 2'd0);
        chk1("u1 F11", 10, 8, 1, 1);
        chk("pre-reset u0 commit", 32'(b0.Commit), 32'd1);
        #3;
        RESET = 1'b0;
        #1;
        chk1("async reset u1", 0, 0, 0, 0);
        chk("async reset u0 commit", 32'(b0.Commit), 32'd0);
        chk("async reset u0 busy",   32'(b0.Busy),   32'd0);
        chk("async reset u0 addr",   32'(b0.Address), 32'd0);
        drive(16'h0000, 1'b0, 2'd0);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Randomised byte stream against the reference model.
        m0 = mclear();
        m1 = mclear();
        kbw = 16'h0000;
        prev_kb = 16'h0000;
        for (int s = 0; s < 2000; s++) begin
            if ($urandom_range(0, 4) != 0) begin
                if ($urandom_range(0, 9) == 0) nb = 8'($urandom);
                else nb = rnd_codes[$urandom_range(0, 20)];
                kbw = {kbw[7:0], nb};
            end
            rs = ($urandom_range(0, 3) == 0);
            ds = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom);
            drive(kbw, rs, ds);
            @(posedge CLK);
            evt = (kbw != prev_kb);
            prev_kb = kbw;
            m0 = mstep(m0, 3, 2, evt, kbw, rs && ds == 2'b10);
            m1 = mstep(m1, 4, 3, evt, kbw, rs && ds == 2'b10);
            #1;
            chk($sformatf("rnd%0d u0 addr", s),   32'(b0.Address), 32'(exp_addr(m0)));
            chk($sformatf("rnd%0d u0 data", s),   32'(b0.Data),    32'(exp_data(m0)));
            chk($sformatf("rnd%0d u0 commit", s), 32'(b0.Commit),  32'(m0.mode == 2));
            chk($sformatf("rnd%0d u0 busy", s),   32'(b0.Busy),    32'(m0.mode != 0));
            chk($sformatf("rnd%0d u1 addr", s),   32'(b1.Address), 32'(exp_addr(m1)));
            chk($sformatf("rnd%0d u1 data", s),   32'(b1.Data),    32'(exp_data(m1)));
            chk($sformatf("rnd%0d u1 commit", s), 32'(b1.Commit),  32'(m1.mode == 2));
            chk($sformatf("rnd%0d u1 busy", s),   32'(b1.Busy),    32'(m1.mode != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
